// File: rtl/credit_tx.sv
// credit_tx: transmit side of a credit-flow-controlled link.
// Accepts a local ready/valid stream and forwards each accepted beat on a
// registered, valid-only link. A credit counter mirrors the free slots in the
// remote receive queue. Each beat sent consumes one credit, and each
// credit-return pulse restores one. A return that would push the count past
// the queue depth is treated as a protocol fault: the count saturates and a
// sticky error flag is raised.

module credit_tx #(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 2,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             io_enq_ready,
  input  logic             io_enq_valid,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_tx_valid,
  output logic [WIDTH-1:0] io_tx_bits,
  input  logic             io_credit_return,
  output logic [CW-1:0]    io_credits,
  output logic             io_err
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic          fire;

  // A returned credit only becomes visible after it has been registered into
  // cnt, so ready never depends combinationally on io_credit_return.
  assign io_enq_ready = (cnt != '0);
  assign fire         = io_enq_valid & io_enq_ready;
  assign io_credits   = cnt;

  // Link output stage: one registered beat per accepted enqueue.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_tx_valid <= 1'b0;
      io_tx_bits  <= '0;
    end else begin
      io_tx_valid <= fire;
      if (fire) begin
        io_tx_bits <= io_enq_bits;
      end
    end
  end

  // Credit counter with saturating overflow detection and a sticky error flag.
  // A send and a return in the same cycle cancel out. This is safe even at
  // full credit, because a send requires cnt != 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= FULL;
      io_err <= 1'b0;
    end else begin
      case ({fire, io_credit_return})
        2'b10: cnt <= cnt - ONE;
        2'b01: begin
          if (cnt == FULL) begin
            io_err <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_credit_tx.sv
// Testbench for credit_tx. It runs a directed vector table that walks the
// credit corner cases, then applies randomized traffic. The random traffic is
// checked against a credit-accounting model kept in the bench.

module tb_credit_tx;

  localparam int WIDTH   = 8;
  localparam int CREDITS = 2;
  localparam int CW      = $clog2(CREDITS + 1);

  logic             clk;
  logic             reset;
  logic             io_enq_ready;
  logic             io_enq_valid;
  logic [WIDTH-1:0] io_enq_bits;
  logic             io_tx_valid;
  logic [WIDTH-1:0] io_tx_bits;
  logic             io_credit_return;
  logic [CW-1:0]    io_credits;
  logic             io_err;

  credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk              (clk),
    .reset            (reset),
    .io_enq_ready     (io_enq_ready),
    .io_enq_valid     (io_enq_valid),
    .io_enq_bits      (io_enq_bits),
    .io_tx_valid      (io_tx_valid),
    .io_tx_bits       (io_tx_bits),
    .io_credit_return (io_credit_return),
    .io_credits       (io_credits),
    .io_err           (io_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state: plain integer credit accounting.
  int       m_credits;
  bit       m_err;
  bit       m_tx_valid;
  bit [7:0] m_tx_bits;

  typedef struct {
    bit       rst;
    bit       v;
    bit [7:0] d;
    bit       ret;
    bit       chk_rdy;
    bit       e_rdy;
    bit       e_txv;
    bit [7:0] e_txb;
    int       e_cr;
    bit       e_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input bit [7:0] d, input bit ret);
    bit f;
    if (rst) begin
      m_credits  = CREDITS;
      m_err      = 0;
      m_tx_valid = 0;
      m_tx_bits  = 0;
    end else begin
      f = v && (m_credits > 0);
      m_tx_valid = f;
      if (f) m_tx_bits = d;
      m_credits = m_credits + (ret ? 1 : 0) - (f ? 1 : 0);
      if (m_credits > CREDITS) begin
        m_credits = CREDITS;
        m_err     = 1;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit [7:0] d, input bit ret);
    reset            = rst;
    io_enq_valid     = v;
    io_enq_bits      = d;
    io_credit_return = ret;
    #2;
  endtask

  task automatic add(input bit rst, v, input bit [7:0] d, input bit ret, chk_rdy, e_rdy, e_txv,
                     input bit [7:0] e_txb, input int e_cr, input bit e_err);
    vec_t x;
    x.rst = rst; x.v = v; x.d = d; x.ret = ret; x.chk_rdy = chk_rdy; x.e_rdy = e_rdy;
    x.e_txv = e_txv; x.e_txb = e_txb; x.e_cr = e_cr; x.e_err = e_err;
    vt.push_back(x);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    io_enq_valid = 1'b0;
    io_enq_bits = '0;
    io_credit_return = 1'b0;
    m_credits = CREDITS;
    m_err = 0;
    m_tx_valid = 0;
    m_tx_bits = 0;

    //   rst v  data   ret chk rdy txv txb    cr err
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2, 0);
    add(1, 0, 8'h00, 0, 1, 1, 0, 8'h00, 2, 0);
    add(0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 2, 0);
    add(0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 2, 0);
    add(0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 2, 0);
    add(0, 1, 8'hA5, 0, 1, 1, 1, 8'hA5, 1, 0);
    add(0, 1, 8'h3C, 0, 1, 1, 1, 8'h3C, 0, 0);
    add(0, 1, 8'h77, 0, 1, 0, 0, 8'h3C, 0, 0);
    add(0, 1, 8'h77, 1, 1, 0, 0, 8'h3C, 1, 0);
    add(0, 1, 8'h77, 0, 1, 1, 1, 8'h77, 0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 8'h77, 1, 0);
    add(0, 1, 8'h11, 1, 1, 1, 1, 8'h11, 1, 0);
    add(0, 0, 8'h00, 1, 1, 1, 0, 8'h11, 2, 0);
    add(0, 0, 8'h00, 1, 1, 1, 0, 8'h11, 2, 1);
    add(0, 1, 8'h22, 0, 1, 1, 1, 8'h22, 1, 1);
    add(0, 1, 8'h33, 0, 1, 1, 1, 8'h33, 0, 1);
    add(1, 1, 8'h44, 1, 1, 0, 0, 8'h00, 2, 0);
    add(0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 2, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].v, vt[i].d, vt[i].ret);
      if (vt[i].chk_rdy) chk("tbl_enq_ready", i, 32'(io_enq_ready), 32'(vt[i].e_rdy));
      model_step(vt[i].rst, vt[i].v, vt[i].d, vt[i].ret);
      @(posedge clk);
      #1;
      chk("tbl_tx_valid", i, 32'(io_tx_valid), 32'(vt[i].e_txv));
      chk("tbl_tx_bits",  i, 32'(io_tx_bits),  32'(vt[i].e_txb));
      chk("tbl_credits",  i, 32'(io_credits),  32'(vt[i].e_cr));
      chk("tbl_err",      i, 32'(io_err),      32'(vt[i].e_err));
    end

    // Randomized traffic, with occasional resets to clear the sticky error.
    for (int c = 0; c < 600; c++) begin
      bit       r, v, ret;
      bit [7:0] d;
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 99) < 70);
      ret = ($urandom_range(0, 99) < 40);
      d   = 8'($urandom);
      drive(r, v, d, ret);
      chk("rnd_enq_ready", c, 32'(io_enq_ready), 32'(m_credits > 0));
      model_step(r, v, d, ret);
      @(posedge clk);
      #1;
      chk("rnd_tx_valid", c, 32'(io_tx_valid), 32'(m_tx_valid));
      chk("rnd_tx_bits",  c, 32'(io_tx_bits),  32'(m_tx_bits));
      chk("rnd_credits",  c, 32'(io_credits),  32'(m_credits));
      chk("rnd_err",      c, 32'(io_err),      32'(m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmit end of a credit-flow-controlled link whose far end is a fixed-depth receive queue with no ready back-pressure wire.
- Accepts a local ready/valid (decoupled) stream and forwards each accepted beat on a registered, valid-only link.
- Tracks how many receiver slots are free by counting credits. A credit is consumed per beat sent and restored per credit-return pulse from the receiver.
- Sits between a producer and a long or pipelined wire to a remote queue; replaces a direct ready path.

Parameters:
- WIDTH, 8, data bits per beat
- CREDITS, 2, receiver queue depth; initial and maximum credit count (must be >= 1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- io_enq_ready  output  1  local producer may transfer this cycle
- io_enq_valid  input  1  local producer has a beat
- io_enq_bits  input  WIDTH  local beat data
- io_tx_valid  output  1  link beat valid (registered)
- io_tx_bits  output  WIDTH  link beat data (registered)
- io_credit_return  input  1  one-cycle pulse: receiver freed one slot
- io_credits  output  CW  current credit count, CW = clog2(CREDITS+1)
- io_err  output  1  sticky: credit overflow detected

Behaviour:
- Reset (synchronous, active-high; takes priority over every other event):
  - cnt <= CREDITS, io_tx_valid <= 0, io_tx_bits <= 0, io_err <= 0.
  - io_credit_return and io_enq_valid are ignored in any cycle where reset is high.
  - Reset mid-operation discards the in-flight io_tx beat and restores full credit.
- io_enq_ready = (cnt != 0). Purely combinational from the cnt register; independent of io_enq_valid and io_credit_return.
- fire = io_enq_valid & io_enq_ready.
- Link output stage:
  - io_tx_valid <= fire every cycle.
  - io_tx_bits <= io_enq_bits when fire; holds its previous value otherwise.
  - Latency enq to tx is exactly 1 cycle.
  - One beat per cycle maximum; back-to-back beats are allowed while credits remain.
- Credit counter, next value:
  - fire & !credit_return: cnt - 1.
  - !fire & credit_return: cnt + 1, but if cnt == CREDITS, cnt holds and io_err <= 1.
  - fire & credit_return: cnt unchanged. This is legal even at cnt == CREDITS, since fire implies cnt > 0.
  - neither: hold.
- A credit returned in cycle N is usable in cycle N+1; there is no same-cycle bypass into io_enq_ready.
- Underflow is impossible by construction, because fire requires cnt != 0.
- io_err stays set until reset.
- io_credits is the cnt register, exposed directly.
- Arithmetic uses CW-bit unsigned values with no wrap. The overflow case is saturated as described above.
- CREDITS == 1 degenerates to stop-and-wait: one beat, then io_enq_ready low until the credit returns.

Test Plan:
- Reset, then idle 3 cycles -> io_credits = 2, io_enq_ready = 1, io_tx_valid = 0, io_err = 0.
- Enqueue 0xA5 and 0x3C back-to-back with no returns -> io_tx shows 0xA5 then 0x3C, each 1 cycle after accept. io_credits goes 2→1→0. io_enq_ready = 0 from the third cycle while io_enq_valid stays high. No further tx beats.
- At 0 credits, pulse io_credit_return once -> io_enq_ready rises the next cycle. The held beat 0x77 is accepted then and appears on io_tx one cycle later. io_credits goes back to 0.
- At 1 credit, assert enq (0x11) and io_credit_return in the same cycle -> beat sent, io_credits stays 1, io_err = 0.
- At full credits (2), pulse io_credit_return with no enq -> io_credits stays 2, io_err = 1 and remains 1 through later traffic until reset.
- Assert reset while a tx beat is valid and credits = 0 -> next cycle io_tx_valid = 0, io_credits = 2, io_err = 0. A credit_return pulse coincident with reset has no effect.
